// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RISC-V control unit.
// A Moore FSM sequences fetch/decode/execute/memory/writeback for the shared-ALU,
// shared-memory datapath. It also resolves beq/bne, traps illegal opcodes and
// counts retired instructions. The datapath controls decode combinationally from
// the registered state. Only PCWrite and IRWrite also look at live inputs.
module riscv_multicycle_ctrl #(
    parameter int CNT_W       = 32,
    parameter bit TRAP_STICKY = 1'b1,
    parameter bit BNE_EN      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             trap,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    logic             pcwrite_raw, irwrite_raw, memwrite_raw, regwrite_raw;

    // Only funct3[0] matters here (beq vs bne); the other bits are for the ALU decoder.
    logic unused_funct3;
    assign unused_funct3 = ^funct3[2:1];

    // Next-state selection and retirement detection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     if (!TRAP_STICKY) state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase

        // A jal retires through ALUWB, so it is not counted in JAL itself.
        retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
                 ((state_q == S_MEMWRITE) && mem_ready);
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    end

    // State and retired-instruction counter registers; reset abandons any instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Per-state datapath controls; strobes are computed raw and gated by reset below.
    always_comb begin
        pcwrite_raw  = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        trap         = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                irwrite_raw = mem_ready;
                pcwrite_raw = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc    = 2'b01;
                regwrite_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc       = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB:    regwrite_raw = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 2'b10;
                ALUOp       = 2'b01;
                pcwrite_raw = zero ^ (BNE_EN && funct3[0]);
            end
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                pcwrite_raw = 1'b1;
            end
            S_TRAP:     trap = 1'b1;
            default:    trap = 1'b0;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BR:   ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite  = pcwrite_raw  & ~reset;
    assign IRWrite  = irwrite_raw  & ~reset;
    assign MemWrite = memwrite_raw & ~reset;
    assign RegWrite = regwrite_raw & ~reset;
    assign instret  = instret_q;
    assign state    = state_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl. Two instances are used:
// dut1 has the default parameters (sticky trap, 32-bit counter).
// dut2 has a non-sticky trap and a 4-bit counter, for trap exit and counter wrap.
// Expected per-cycle values are queued when stimulus is driven and checked at the negedge.
module tb_riscv_multicycle_ctrl;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_ILL = 7'b0110111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, rst2, dsel;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero, mem_ready;

    logic        pcw1, adr1, memw1, irw1, regw1, trap1;
    logic [1:0]  rs1, sa1, sb1, aop1, imm1;
    logic [31:0] cnt1;
    logic [3:0]  st1;
    logic        pcw2, adr2, memw2, irw2, regw2, trap2;
    logic [1:0]  rs2, sa2, sb2, aop2, imm2;
    logic [3:0]  cnt2;
    logic [3:0]  st2;

    riscv_multicycle_ctrl dut1 (
        .clk(clk), .reset(rst1), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(memw1), .IRWrite(irw1), .RegWrite(regw1),
        .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUOp(aop1), .ImmSrc(imm1),
        .trap(trap1), .instret(cnt1), .state(st1)
    );

    riscv_multicycle_ctrl #(.CNT_W(4), .TRAP_STICKY(1'b0), .BNE_EN(1'b1)) dut2 (
        .clk(clk), .reset(rst2), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(memw2), .IRWrite(irw2), .RegWrite(regw2),
        .ResultSrc(rs2), .ALUSrcA(sa2), .ALUSrcB(sb2), .ALUOp(aop2), .ImmSrc(imm2),
        .trap(trap2), .instret(cnt2), .state(st2)
    );

    logic [3:0]  obs_st, obs_stb;
    logic [11:0] obs_ctl;
    logic [31:0] obs_cnt;
    assign obs_st  = dsel ? st2 : st1;
    assign obs_stb = dsel ? {pcw2, irw2, memw2, regw2} : {pcw1, irw1, memw1, regw1};
    assign obs_ctl = dsel ? {adr2, rs2, sa2, sb2, aop2, imm2, trap2}
                          : {adr1, rs1, sa1, sb1, aop1, imm1, trap1};
    assign obs_cnt = dsel ? {28'd0, cnt2} : cnt1;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [3:0]  stb;   // {PCWrite, IRWrite, MemWrite, RegWrite}
        logic [11:0] ctl;   // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, trap}
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Mux/trap controls expected in a state, straight from the state output table.
    function automatic logic [11:0] spec_ctl(input logic [3:0] s, input logic [6:0] o);
        logic       adr, tr;
        logic [1:0] rs, a, b, alu, imm;
        adr = 1'b0; tr = 1'b0; rs = 2'b00; a = 2'b00; b = 2'b00; alu = 2'b00;
        case (o)
            OP_LW:   imm = 2'b00;
            OP_SW:   imm = 2'b01;
            OP_BR:   imm = 2'b10;
            OP_JAL:  imm = 2'b11;
            default: imm = 2'b00;
        endcase
        case (s)
            4'd0:  begin rs = 2'b10; b = 2'b10; end
            4'd1:  begin a = 2'b01; b = 2'b01; end
            4'd2:  begin a = 2'b10; b = 2'b01; end
            4'd3:  adr = 1'b1;
            4'd4:  rs = 2'b01;
            4'd5:  adr = 1'b1;
            4'd6:  begin a = 2'b10; alu = 2'b10; end
            4'd7:  begin a = 2'b10; b = 2'b01; alu = 2'b10; end
            4'd9:  begin a = 2'b10; alu = 2'b01; end
            4'd10: begin a = 2'b01; b = 2'b10; end
            4'd11: tr = 1'b1;
            default: ;
        endcase
        return {adr, rs, a, b, alu, imm, tr};
    endfunction

    task automatic check_out();
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        assert (obs_st === e.st) else begin
            errors++;
            $error("FAIL %s state: got %0d expected %0d", e.tag, obs_st, e.st);
        end
        checks++;
        assert (obs_stb === e.stb) else begin
            errors++;
            $error("FAIL %s strobes: got %b expected %b", e.tag, obs_stb, e.stb);
        end
        checks++;
        assert (obs_ctl === e.ctl) else begin
            errors++;
            $error("FAIL %s controls: got %b expected %b", e.tag, obs_ctl, e.ctl);
        end
        checks++;
        assert (obs_cnt === e.cnt) else begin
            errors++;
            $error("FAIL %s instret: got %0d expected %0d", e.tag, obs_cnt, e.cnt);
        end
        $display("cycle %-14s state=%0d strobes=%b ctl=%b instret=%0d", e.tag, obs_st, obs_stb,
                 obs_ctl, obs_cnt);
    endtask

    // One clock cycle: drive inputs, queue the expectation, check at the negedge.
    task automatic cyc(input string tag, input logic mr, input logic z, input logic [3:0] est,
                       input logic [3:0] estb, input logic [31:0] ecnt);
        exp_t e;
        mem_ready = mr;
        zero      = z;
        e.tag = tag; e.st = est; e.stb = estb; e.ctl = spec_ctl(est, op); e.cnt = ecnt;
        sb_q.push_back(e);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst1 = 1'b1; rst2 = 1'b1; dsel = 1'b0;
        op = OP_LW; funct3 = 3'b010; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset holds strobes low even in FETCH with mem_ready high.
        cyc("rst_hold", 1, 0, 4'd0, 4'b0000, 0);
        rst1 = 1'b0;
        cyc("rst_state", 0, 0, 4'd0, 4'b0000, 0);

        // lw with 2-cycle stalls in FETCH and MEMREAD.
        cyc("lw_f0", 0, 0, 4'd0, 4'b0000, 0);
        cyc("lw_f1", 0, 0, 4'd0, 4'b0000, 0);
        cyc("lw_f2", 1, 0, 4'd0, 4'b1100, 0);
        cyc("lw_dec", 0, 0, 4'd1, 4'b0000, 0);
        cyc("lw_adr", 0, 0, 4'd2, 4'b0000, 0);
        cyc("lw_rd0", 0, 0, 4'd3, 4'b0000, 0);
        cyc("lw_rd1", 0, 0, 4'd3, 4'b0000, 0);
        cyc("lw_rd2", 1, 0, 4'd3, 4'b0000, 0);
        cyc("lw_wb", 0, 0, 4'd4, 4'b0001, 0);
        cyc("lw_done", 0, 0, 4'd0, 4'b0000, 1);

        // Reset in the middle of a MEMREAD wait.
        cyc("mid_f", 1, 0, 4'd0, 4'b1100, 1);
        cyc("mid_dec", 0, 0, 4'd1, 4'b0000, 1);
        cyc("mid_adr", 0, 0, 4'd2, 4'b0000, 1);
        cyc("mid_rd", 0, 0, 4'd3, 4'b0000, 1);
        rst1 = 1'b1;
        cyc("mid_rst", 0, 0, 4'd3, 4'b0000, 1);
        rst1 = 1'b0;
        cyc("mid_after", 0, 0, 4'd0, 4'b0000, 0);

        // Branch resolution.
        op = OP_BR; funct3 = 3'b000;
        cyc("beq_t_f", 1, 0, 4'd0, 4'b1100, 0);
        cyc("beq_t_d", 0, 0, 4'd1, 4'b0000, 0);
        cyc("beq_t_br", 0, 1, 4'd9, 4'b1000, 0);
        funct3 = 3'b001;
        cyc("bne_nt_f", 1, 0, 4'd0, 4'b1100, 1);
        cyc("bne_nt_d", 0, 0, 4'd1, 4'b0000, 1);
        cyc("bne_nt_br", 0, 1, 4'd9, 4'b0000, 1);
        cyc("bne_t_f", 1, 0, 4'd0, 4'b1100, 2);
        cyc("bne_t_d", 0, 0, 4'd1, 4'b0000, 2);
        cyc("bne_t_br", 0, 0, 4'd9, 4'b1000, 2);
        funct3 = 3'b000;
        cyc("beq_nt_f", 1, 0, 4'd0, 4'b1100, 3);
        cyc("beq_nt_d", 0, 0, 4'd1, 4'b0000, 3);
        cyc("beq_nt_br", 0, 0, 4'd9, 4'b0000, 3);

        // sw with a 1-cycle stall in MEMWRITE.
        op = OP_SW; funct3 = 3'b010;
        cyc("sw_f", 1, 0, 4'd0, 4'b1100, 4);
        cyc("sw_dec", 0, 0, 4'd1, 4'b0000, 4);
        cyc("sw_adr", 0, 0, 4'd2, 4'b0000, 4);
        cyc("sw_wr0", 0, 0, 4'd5, 4'b0010, 4);
        cyc("sw_wr1", 1, 0, 4'd5, 4'b0010, 4);

        // jal, then R-type and I-type.
        op = OP_JAL;
        cyc("jal_f", 1, 0, 4'd0, 4'b1100, 5);
        cyc("jal_dec", 0, 0, 4'd1, 4'b0000, 5);
        cyc("jal_jal", 0, 0, 4'd10, 4'b1000, 5);
        cyc("jal_wb", 0, 0, 4'd8, 4'b0001, 5);
        op = OP_R;
        cyc("r_f", 1, 0, 4'd0, 4'b1100, 6);
        cyc("r_dec", 0, 0, 4'd1, 4'b0000, 6);
        cyc("r_ex", 0, 0, 4'd6, 4'b0000, 6);
        cyc("r_wb", 0, 0, 4'd8, 4'b0001, 6);
        op = OP_I;
        cyc("i_f", 1, 0, 4'd0, 4'b1100, 7);
        cyc("i_dec", 0, 0, 4'd1, 4'b0000, 7);
        cyc("i_ex", 0, 0, 4'd7, 4'b0000, 7);
        cyc("i_wb", 0, 0, 4'd8, 4'b0001, 7);

        // Illegal opcode with a sticky trap.
        op = OP_ILL;
        cyc("ill_f", 1, 0, 4'd0, 4'b1100, 8);
        cyc("ill_dec", 1, 0, 4'd1, 4'b0000, 8);
        for (int i = 0; i < 20; i++)
            cyc($sformatf("trap_%0d", i), 1'(i % 2), 0, 4'd11, 4'b0000, 8);
        rst1 = 1'b1;
        cyc("trap_rst", 1, 0, 4'd11, 4'b0000, 8);

        // Switch to the non-sticky, 4-bit-counter instance.
        dsel = 1'b1;
        cyc("d2_rst", 1, 0, 4'd0, 4'b0000, 0);
        rst2 = 1'b0;
        cyc("d2_ill_f", 1, 0, 4'd0, 4'b1100, 0);
        cyc("d2_ill_dec", 0, 0, 4'd1, 4'b0000, 0);
        cyc("d2_trap", 0, 0, 4'd11, 4'b0000, 0);
        cyc("d2_trap_exit", 0, 0, 4'd0, 4'b0000, 0);

        // 17 back-to-back R-type instructions wrap the 4-bit counter to 1.
        op = OP_R;
        for (int i = 0; i < 17; i++) begin
            cyc($sformatf("wrap%0d_f", i), 1, 0, 4'd0, 4'b1100, 32'(i % 16));
            cyc($sformatf("wrap%0d_d", i), 0, 0, 4'd1, 4'b0000, 32'(i % 16));
            cyc($sformatf("wrap%0d_x", i), 0, 0, 4'd6, 4'b0000, 32'(i % 16));
            cyc($sformatf("wrap%0d_w", i), 0, 0, 4'd8, 4'b0001, 32'(i % 16));
        end
        cyc("wrap_end", 0, 0, 4'd0, 4'b0000, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Multicycle RISC-V control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles and drives the shared-ALU/shared-memory datapath. It supersedes the single-cycle main decoder for the multicycle core and adds several features:
- a memory ready handshake that stretches memory states;
- `beq`/`bne` branch resolution;
- an illegal-opcode trap state;
- a retired-instruction counter.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter `instret`
- `TRAP_STICKY`, 1, 1 = TRAP held until reset; 0 = TRAP lasts one cycle, then FETCH
- `BNE_EN`, 1, 1 = `funct3[0]` selects `bne`; 0 = every branch resolves as `beq`

Ports:
- `clk` in 1 — rising-edge clock; one clock domain
- `reset` in 1 — synchronous, active-high
- `op` in 7 — opcode field of the instruction register
- `funct3` in 3 — funct3 field of the instruction register
- `zero` in 1 — ALU zero flag
- `mem_ready` in 1 — memory has completed the current access this cycle
- `PCWrite` out 1 — PC register enable
- `AdrSrc` out 1 — memory address select: 0 = PC, 1 = ALUOut
- `MemWrite` out 1 — memory write strobe
- `IRWrite` out 1 — instruction/OldPC register enable
- `RegWrite` out 1 — register file write enable
- `ResultSrc` out 2 — result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- `ALUSrcA` out 2 — ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- `ALUSrcB` out 2 — ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
- `ALUOp` out 2 — 00 = add, 01 = subtract, 10 = funct-decoded
- `ImmSrc` out 2 — immediate format
- `trap` out 1 — illegal opcode detected
- `instret` out `CNT_W` — retired-instruction count
- `state` out 4 — current state, for debug

## Operation
State encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
- EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=11
- Codes 12–15 are unreachable; if entered, the next state is FETCH.

Output defaults:
- Every output not listed for a state below is 0.
- `ImmSrc` is combinational from `op` in every state: `lw`=00, `sw`=01, branch=10, `jal`=11, others=00.

Per-state outputs and transitions:
- **FETCH**: `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10.
  - `IRWrite` and `PCWrite` are driven equal to `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- **DECODE**: `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00 (branch target into ALUOut). Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - anything else → TRAP
- **MEMADR**: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00. Next is MEMREAD if `op`=0000011, else MEMWRITE.
- **MEMREAD**: `AdrSrc`=1, `ResultSrc`=00. Holds until `mem_ready`=1, then MEMWB.
- **MEMWB**: `ResultSrc`=01, `RegWrite`=1. Next FETCH.
- **MEMWRITE**: `AdrSrc`=1, `ResultSrc`=00, `MemWrite`=1.
  - `MemWrite` stays high until the cycle `mem_ready`=1, then FETCH.
- **EXECUTER**: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10. Next ALUWB.
- **EXECUTEI**: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10. Next ALUWB.
- **ALUWB**: `ResultSrc`=00, `RegWrite`=1. Next FETCH.
- **BRANCH**: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00.
  - `PCWrite` = `zero` XOR (`BNE_EN` & `funct3[0]`).
  - Next FETCH.
- **JAL**: `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=00, `PCWrite`=1. Next ALUWB.
- **TRAP**: `trap`=1; all strobes 0.
  - If `TRAP_STICKY`=1, stays in TRAP until reset.
  - If `TRAP_STICKY`=0, goes to FETCH after one cycle.

Retired-instruction counter:
- `instret` increments by 1 on the clock edge that leaves any of: MEMWB, ALUWB, BRANCH, or MEMWRITE with `mem_ready`=1.
- A `jal` retires via ALUWB.
- Wraps modulo 2^`CNT_W`.
- TRAP does not count.

## Timing
Reset:
- On `reset`=1 at a clock edge: `state` becomes FETCH and `instret` becomes 0.
- While `reset` is high, `PCWrite`, `IRWrite`, `MemWrite` and `RegWrite` are forced to 0 regardless of state.
- Reset mid-instruction, including inside a memory wait or in TRAP, abandons the instruction with no write strobe and no count.

Outputs and cycle counts:
- All outputs except `PCWrite` (FETCH, BRANCH) and `IRWrite` (FETCH) are pure functions of `state` and `op`.
- Minimum latency with zero-wait memory, FETCH through last state inclusive:
  - `lw`: 5 cycles
  - `sw`: 4 cycles
  - R-type: 4 cycles
  - I-type: 4 cycles
  - `jal`: 4 cycles
  - branch: 3 cycles
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- `mem_ready` is sampled only in FETCH, MEMREAD and MEMWRITE; it is ignored in all other states.
- `op` and `funct3` must be stable from DECODE until the instruction completes; the instruction register provides this.

## Test plan
- **Reset mid-instruction**: assert `reset` for one cycle while in MEMREAD with `mem_ready`=0 → the next cycle shows `state`=0, `instret`=0, and no `RegWrite` pulse.
- **`lw` with a 2-cycle memory stall**: `op`=0000011, `mem_ready` low for 2 cycles in both FETCH and MEMREAD → the state sequence is 0,0,0,1,2,3,3,3,4,0; `RegWrite`=1 only in state 4; `instret` goes 0→1.
- **Branch resolution**: `op`=1100011, `BNE_EN`=1.
  - `funct3`=000 with `zero`=1 → `PCWrite`=1 in BRANCH.
  - `funct3`=001 with `zero`=1 → `PCWrite`=0.
  - `funct3`=001 with `zero`=0 → `PCWrite`=1.
  - Each case takes 3 cycles and increments `instret`.
- **`sw` write strobe**: `op`=0100011, `mem_ready` low for 1 cycle in MEMWRITE → `MemWrite` is high for exactly 2 cycles and `AdrSrc`=1 during them; `RegWrite` is never asserted.
- **`jal`**: `op`=1101111 → states 0,1,10,8,0; `PCWrite`=1 in JAL; `RegWrite`=1 with `ResultSrc`=00 in ALUWB; `ImmSrc`=11 throughout.
- **Illegal opcode**: `op`=0110111 with `TRAP_STICKY`=1 → `trap`=1 held for 20 cycles, `instret` unchanged, until reset. With `TRAP_STICKY`=0 → one TRAP cycle, then FETCH.
- **Counter wrap**: `CNT_W`=4 with 17 back-to-back R-type instructions → `instret` reads 1 after the 17th.
